// File: rtl/cfg_bus_arbiter_pkg.sv
// Shared types, default widths and the config address map for the config-bus arbiter.
package cfg_bus_arbiter_pkg;

  localparam int unsigned NUM_REQ_DEF        = 4;
  localparam int unsigned CFG_ADDR_W         = 4;
  localparam int unsigned CFG_DATA_W         = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_DRIVE = 1'b1
  } arb_state_e;

  // Config address map of the slave blocks behind the bus
  localparam logic [CFG_ADDR_W-1:0] UART_PARITY_ADDR = 4'h4;
  localparam logic [CFG_ADDR_W-1:0] UART_STOP_ADDR   = 4'h5;
  localparam logic [CFG_ADDR_W-1:0] SPI_MODE_ADDR    = 4'h8;
  localparam logic [CFG_ADDR_W-1:0] TIMER_LOAD_ADDR  = 4'hC;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cfg_bus_arbiter_if.sv
// Request side and config-bus side signals of the arbiter; slave = arbiter view, master = requester/fabric view.
interface cfg_bus_arbiter_if
  import cfg_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ           = NUM_REQ_DEF,
  parameter int unsigned WIDTH_CONFIG_ADDR = CFG_ADDR_W,
  parameter int unsigned WIDTH_CONFIG_DATA = CFG_DATA_W
);
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                   req_valid;
  logic [NUM_REQ*WIDTH_CONFIG_ADDR-1:0] req_addr;
  logic [NUM_REQ*WIDTH_CONFIG_DATA-1:0] req_data;
  logic [NUM_REQ-1:0]                   req_ready;
  logic [WIDTH_CONFIG_ADDR-1:0]         c_addr;
  logic [WIDTH_CONFIG_DATA-1:0]         c_data;
  logic                                 c_valid;
  logic                                 c_ready;
  logic [IW-1:0]                        grant_id;
  logic                                 busy;
  logic                                 timeout_err;

  modport slave (
    input  req_valid, req_addr, req_data, c_ready,
    output req_ready, c_addr, c_data, c_valid, grant_id, busy, timeout_err
  );

  modport master (
    output req_valid, req_addr, req_data, c_ready,
    input  req_ready, c_addr, c_data, c_valid, grant_id, busy, timeout_err
  );

endinterface

// File: rtl/cfg_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after i_ptr, wrapping modulo NUM_REQ.
module cfg_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_grant_c,
  output logic [IW-1:0]      o_grant_idx_c,
  output logic               o_any_req_c
);

  logic          w_found;
  int unsigned   w_idx;
  logic [IW-1:0] w_sel;

  always_comb begin
    o_grant_c     = '0;
    o_grant_idx_c = '0;
    o_any_req_c   = |i_req;
    w_found       = 1'b0;
    w_idx         = 0;
    w_sel         = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = 32'(i_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      w_sel = IW'(w_idx);
      if (!w_found && i_req[w_sel]) begin
        w_found          = 1'b1;
        o_grant_c[w_sel] = 1'b1;
        o_grant_idx_c    = w_sel;
      end
    end
  end

endmodule

// File: rtl/cfg_bus_arbiter.sv
// Round-robin config-bus write arbiter with forced idle cycle between writes.
// Optional DRIVE watchdog enabled by macro CFG_ARB_TIMEOUT_EN.
module cfg_bus_arbiter
  import cfg_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ           = NUM_REQ_DEF,
  parameter int unsigned WIDTH_CONFIG_ADDR = CFG_ADDR_W,
  parameter int unsigned WIDTH_CONFIG_DATA = CFG_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES    = TIMEOUT_CYCLES_DEF
) (
  input logic              clk,
  input logic              rst,
  cfg_bus_arbiter_if.slave io_bus
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned AW = WIDTH_CONFIG_ADDR;
  localparam int unsigned DW = WIDTH_CONFIG_DATA;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_chk
    $error("cfg_bus_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  arb_state_e    r_state, w_state_nxt;
  logic [AW-1:0] r_c_addr, w_addr_nxt;
  logic [DW-1:0] r_c_data, w_data_nxt;
  logic          r_c_valid, w_valid_nxt;
  logic [IW-1:0] r_grant_id, w_gid_nxt;
  logic [IW-1:0] r_ptr, w_ptr_nxt;

  logic [NUM_REQ-1:0] w_grant_oh;
  logic [IW-1:0]      w_win_idx;
  logic               w_any_req;
  logic [AW-1:0]      w_win_addr;
  logic [DW-1:0]      w_win_data;
  logic               w_done;
  logic               w_abort;
  logic               w_strobe;

  cfg_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .i_req         (io_bus.req_valid),
    .i_ptr         (r_ptr),
    .o_grant_c     (w_grant_oh),
    .o_grant_idx_c (w_win_idx),
    .o_any_req_c   (w_any_req)
  );

  // One-hot AND-OR mux of the winner's payload
  always_comb begin
    w_win_addr = '0;
    w_win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant_oh[i]) begin
        w_win_addr = w_win_addr | io_bus.req_addr[i*AW +: AW];
        w_win_data = w_win_data | io_bus.req_data[i*DW +: DW];
      end
    end
  end

`ifdef CFG_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] r_tmo_cnt, w_tmo_nxt;

  // Counts DRIVE cycles without c_ready; aborts in the TIMEOUT_CYCLES-th such cycle
  always_comb begin
    w_tmo_nxt = r_tmo_cnt;
    w_abort   = 1'b0;
    if (r_state == ARB_IDLE) begin
      w_tmo_nxt = '0;
    end else if (!io_bus.c_ready) begin
      if (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) w_abort = 1'b1;
      else                                      w_tmo_nxt = r_tmo_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tmo_cnt <= '0;
    else     r_tmo_cnt <= w_tmo_nxt;
  end
`else
  assign w_abort = 1'b0;
`endif

  // Next-state and bus-register logic
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_c_addr;
    w_data_nxt  = r_c_data;
    w_valid_nxt = r_c_valid;
    w_gid_nxt   = r_grant_id;
    w_ptr_nxt   = r_ptr;
    w_done      = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        w_valid_nxt = 1'b0;
        if (w_any_req) begin
          w_addr_nxt  = w_win_addr;
          w_data_nxt  = w_win_data;
          w_valid_nxt = 1'b1;
          w_gid_nxt   = w_win_idx;
          w_state_nxt = ARB_DRIVE;
        end
      end
      ARB_DRIVE: begin
        w_valid_nxt = 1'b1;
        w_done      = io_bus.c_ready;
        if (w_done || w_abort) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = ARB_IDLE;
          w_ptr_nxt   = IW'(rr_next(32'(r_grant_id), NUM_REQ));
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ARB_IDLE;
      r_c_addr   <= '0;
      r_c_data   <= '0;
      r_c_valid  <= 1'b0;
      r_grant_id <= '0;
      r_ptr      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_c_addr   <= w_addr_nxt;
      r_c_data   <= w_data_nxt;
      r_c_valid  <= w_valid_nxt;
      r_grant_id <= w_gid_nxt;
      r_ptr      <= w_ptr_nxt;
    end
  end

  // Completion strobe goes straight back to the granted master in the same cycle
  assign w_strobe           = (r_state == ARB_DRIVE) && (io_bus.c_ready || w_abort);
  assign io_bus.req_ready   = w_strobe ? (NUM_REQ'(1) << r_grant_id) : '0;
  assign io_bus.c_addr      = r_c_addr;
  assign io_bus.c_data      = r_c_data;
  assign io_bus.c_valid     = r_c_valid;
  assign io_bus.grant_id    = r_grant_id;
  assign io_bus.busy        = (r_state == ARB_DRIVE);
  assign io_bus.timeout_err = w_abort;

endmodule

// File: tb/tb_cfg_bus_arbiter.sv
// Directed bench for cfg_bus_arbiter; timeout expectations follow CFG_ARB_TIMEOUT_EN.
module tb_cfg_bus_arbiter;
  import cfg_bus_arbiter_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cfg_bus_arbiter_if #(.NUM_REQ(NR), .WIDTH_CONFIG_ADDR(AW), .WIDTH_CONFIG_DATA(DW)) bus ();

  cfg_bus_arbiter #(
    .NUM_REQ           (NR),
    .WIDTH_CONFIG_ADDR (AW),
    .WIDTH_CONFIG_DATA (DW),
    .TIMEOUT_CYCLES    (16)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int pulses;
  logic [AW-1:0] t2_addr [NR];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int unsigned i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.c_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    t2_addr[0] = UART_PARITY_ADDR;
    t2_addr[1] = UART_STOP_ADDR;
    t2_addr[2] = SPI_MODE_ADDR;
    t2_addr[3] = TIMER_LOAD_ADDR;

    // Reset state
    do_reset();
    check_val("rst_c_valid",   32'(bus.c_valid), 0);
    check_val("rst_c_addr",    32'(bus.c_addr), 0);
    check_val("rst_c_data",    32'(bus.c_data), 0);
    check_val("rst_grant_id",  32'(bus.grant_id), 0);
    check_val("rst_busy",      32'(bus.busy), 0);
    check_val("rst_req_ready", 32'(bus.req_ready), 0);
    check_val("rst_tmo_err",   32'(bus.timeout_err), 0);

    // T1 single write
    bus.req_valid = 4'b0001;
    set_master(0, UART_STOP_ADDR, 8'h03);
    bus.c_ready = 1'b1;
    #1;
    check_val("t1_n_valid", 32'(bus.c_valid), 0);
    tick();
    check_val("t1_n1_valid", 32'(bus.c_valid), 1);
    check_val("t1_n1_addr",  32'(bus.c_addr), 32'h5);
    check_val("t1_n1_data",  32'(bus.c_data), 32'h03);
    check_val("t1_n1_ready", 32'(bus.req_ready), 32'b0001);
    check_val("t1_n1_busy",  32'(bus.busy), 1);
    bus.req_valid = '0;
    tick();
    check_val("t1_n2_valid", 32'(bus.c_valid), 0);
    check_val("t1_n2_ready", 32'(bus.req_ready), 0);
    check_val("t1_n2_hold",  32'(bus.c_addr), 32'h5);

    // T2 contention: order 0,1,2,3,0 with an idle cycle between grants
    do_reset();
    for (int unsigned i = 0; i < NR; i++) set_master(i, t2_addr[i], DW'(16 * i + 1));
    bus.req_valid = 4'b1111;
    bus.c_ready   = 1'b1;
    for (int g = 0; g < 5; g++) begin
      tick();
      check_val($sformatf("t2_g%0d_valid", g), 32'(bus.c_valid), 1);
      check_val($sformatf("t2_g%0d_id", g),    32'(bus.grant_id), 32'(g % 4));
      check_val($sformatf("t2_g%0d_addr", g),  32'(bus.c_addr), 32'(t2_addr[g % 4]));
      check_val($sformatf("t2_g%0d_data", g),  32'(bus.c_data), 32'(16 * (g % 4) + 1));
      check_val($sformatf("t2_g%0d_ready", g), 32'(bus.req_ready), 32'(1) << (g % 4));
      tick();
      check_val($sformatf("t2_g%0d_idle", g),  32'(bus.c_valid), 0);
    end

    // T3 backpressure: 5 stalled cycles then accept
    do_reset();
    bus.req_valid = 4'b0100;
    set_master(2, TIMER_LOAD_ADDR, 8'h5A);
    pulses = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (|bus.req_ready) pulses++;
      check_val($sformatf("t3_c%0d_valid", c), 32'(bus.c_valid), 1);
      check_val($sformatf("t3_c%0d_addr", c),  32'(bus.c_addr), 32'hC);
      check_val($sformatf("t3_c%0d_data", c),  32'(bus.c_data), 32'h5A);
      check_val($sformatf("t3_c%0d_ready", c), 32'(bus.req_ready), 0);
    end
    tick();
    bus.c_ready = 1'b1;
    #1;
    if (|bus.req_ready) pulses++;
    check_val("t3_c6_valid", 32'(bus.c_valid), 1);
    check_val("t3_c6_data",  32'(bus.c_data), 32'h5A);
    check_val("t3_c6_ready", 32'(bus.req_ready), 32'b0100);
    bus.req_valid = '0;
    for (int c = 7; c <= 8; c++) begin
      tick();
      if (|bus.req_ready) pulses++;
      check_val($sformatf("t3_c%0d_valid", c), 32'(bus.c_valid), 0);
    end
    check_val("t3_pulses", 32'(pulses), 1);

    // T4 fairness: master 0 re-requests, master 2 is served first
    do_reset();
    set_master(0, UART_PARITY_ADDR, 8'hA0);
    set_master(2, SPI_MODE_ADDR, 8'hA2);
    bus.req_valid = 4'b0101;
    bus.c_ready   = 1'b1;
    tick();
    check_val("t4_first_id", 32'(bus.grant_id), 0);
    tick();
    check_val("t4_gap", 32'(bus.c_valid), 0);
    tick();
    check_val("t4_second_id",    32'(bus.grant_id), 2);
    check_val("t4_second_ready", 32'(bus.req_ready), 32'b0100);
    check_val("t4_second_data",  32'(bus.c_data), 32'hA2);
    bus.req_valid = 4'b0001;
    tick();
    tick();
    check_val("t4_third_id", 32'(bus.grant_id), 0);

    // T5 reset in the middle of DRIVE
    do_reset();
    set_master(0, UART_STOP_ADDR, 8'h11);
    set_master(3, SPI_MODE_ADDR, 8'h77);
    bus.req_valid = 4'b1000;
    tick();
    check_val("t5_drive_id",   32'(bus.grant_id), 3);
    check_val("t5_drive_busy", 32'(bus.busy), 1);
    tick();
    rst         = 1'b1;
    bus.c_ready = 1'b1;
    #1;
    check_val("t5_rst_valid", 32'(bus.c_valid), 0);
    check_val("t5_rst_id",    32'(bus.grant_id), 0);
    check_val("t5_rst_ready", 32'(bus.req_ready), 0);
    check_val("t5_rst_busy",  32'(bus.busy), 0);
    rst           = 1'b0;
    bus.req_valid = 4'b1001;
    tick();
    check_val("t5_after_id",    32'(bus.grant_id), 0);
    check_val("t5_after_data",  32'(bus.c_data), 32'h11);
    check_val("t5_after_ready", 32'(bus.req_ready), 32'b0001);

    // T6 slave never ready
    do_reset();
    set_master(0, UART_PARITY_ADDR, 8'h42);
    bus.req_valid = 4'b0001;
    for (int c = 1; c <= 20; c++) begin
      tick();
`ifdef CFG_ARB_TIMEOUT_EN
      if (c < 16) begin
        check_val($sformatf("t6_c%0d_valid", c), 32'(bus.c_valid), 1);
        check_val($sformatf("t6_c%0d_err", c),   32'(bus.timeout_err), 0);
      end else if (c == 16) begin
        check_val("t6_abort_valid", 32'(bus.c_valid), 1);
        check_val("t6_abort_err",   32'(bus.timeout_err), 1);
        check_val("t6_abort_ready", 32'(bus.req_ready), 32'b0001);
        bus.req_valid = '0;
      end else begin
        check_val($sformatf("t6_c%0d_valid", c), 32'(bus.c_valid), 0);
        check_val($sformatf("t6_c%0d_err", c),   32'(bus.timeout_err), 0);
      end
`else
      check_val($sformatf("t6_c%0d_valid", c), 32'(bus.c_valid), 1);
      check_val($sformatf("t6_c%0d_err", c),   32'(bus.timeout_err), 0);
      check_val($sformatf("t6_c%0d_ready", c), 32'(bus.req_ready), 0);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
